prefetch_queue: RTL and testbench
=================================

Name: prefetch_queue

Overview:
- Byte-granular instruction queue directly downstream of the prefetch address generator and icache return path.
- Accepts 1..4 byte fetch beats plus terminal markers (CS-limit reached, page fault).
- Presents up to 8 oldest bytes to the decoder, which retires a variable byte count per cycle.
- Flushed by pr_reset on every control transfer, in lockstep with the prefetch address generator.

Parameters:
- DEPTH, 16, queue capacity in bytes; power of two, >= 8.
- PTR_W, 4, log2(DEPTH); derived, not overridden.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- pr_reset  in  1  flush; same cycle as prefetch restart
- prefetchfifo_write_do  in  1  data beat valid
- prefetchfifo_write_data  in  32  beat bytes; [7:0] is lowest address
- prefetchfifo_write_length  in  3  valid bytes in beat, 1..4
- prefetchfifo_signal_limit_do  in  1  CS-limit marker
- prefetchfifo_signal_pf_do  in  1  page-fault marker
- prefetchfifo_space_ok  out  1  at least 4 bytes free and no marker pending
- prefetchfifo_used  out  PTR_W+1  bytes held
- fetch  out  64  oldest bytes; [7:0] is oldest; bytes at or beyond fetch_valid driven 0
- fetch_valid  out  4  bytes presented, min(used,8)
- fetch_limit  out  1  queue drained and limit marker pending
- fetch_page_fault  out  1  queue drained and page-fault marker pending
- dec_accept  in  4  bytes retired this cycle, 0..8
- prefetchfifo_overflow  out  1  sticky error: write dropped for lack of space

Behaviour:
- Storage and pointers:
  - Storage is a DEPTH-byte ring.
  - rd_ptr and wr_ptr are PTR_W bits and wrap modulo DEPTH.
  - used is a PTR_W+1 bit register.
- Reset (rst_n=0):
  - Pointers, used, both markers and overflow are cleared.
  - Resulting outputs: fetch_valid=0, fetch=0, fetch_limit=0, fetch_page_fault=0, space_ok=1, used=0.
- Write latency: a byte written in cycle N is visible on fetch in cycle N+1. There is no same-cycle bypass.
- Write acceptance:
  - A write is accepted only if DEPTH-used >= write_length and no marker is pending.
  - Otherwise the beat is dropped whole and overflow is set; overflow is cleared only by rst_n.
  - A write_length of 0 is treated as no write.
- Retire:
  - eff_accept = min(dec_accept, fetch_valid); excess is clamped silently.
  - rd_ptr += eff_accept.
- Simultaneous write and retire:
  - used_next = used + wlen_accepted - eff_accept.
  - Space for acceptance is evaluated on the pre-retire used, so a full queue cannot accept in the same cycle it drains.
- Markers:
  - Each marker is sticky once set; a write in the same cycle as a marker is accepted first (marker logically follows it).
  - Marker inputs arriving while a marker is already pending are ignored.
  - If limit and pf arrive in the same cycle, pf wins.
  - A pending marker blocks all further writes and deasserts space_ok.
- Marker output:
  - fetch_limit / fetch_page_fault = marker pending && used==0.
  - Held until pr_reset or rst_n.
- Flush (pr_reset):
  - Next cycle: pointers, used and markers are cleared.
  - Writes, markers and retires in the pr_reset cycle are discarded.
  - Outputs in the pr_reset cycle still reflect pre-flush state.
  - overflow is not cleared.
- Priority: rst_n > pr_reset > marker/write/retire.
- Wrap-around: reads and writes straddling the DEPTH boundary assemble bytes across the wrap transparently. Byte order is preserved modulo DEPTH.
- Derivation: space_ok and fetch_valid are combinational from registers only, with no input-to-output path. fetch is a byte mux indexed by rd_ptr+i.

Decomposition:
- defines.v (shared) holds:
  - TRUE/FALSE.
  - PREFETCH_QUEUE_DEPTH default.
  - Marker encoding: 2-bit none/limit/pf.
- Natural sub-module: prefetch_queue_ring.
  - Contains the byte RAM with a 4-byte write port at wr_ptr and an 8-byte rotated read window at rd_ptr.
  - Pointer/count/marker control stays in the top.

Test Plan:
- Basic fill and drain:
  - Stimulus: after reset, write 0x44332211 len4 then 0x88776655 len4; dec_accept=0.
  - Response: next cycles used=4 then 8, fetch_valid=8, fetch=0x8877665544332211. Then dec_accept=3 → fetch_valid=5, fetch[7:0]=0x44.
- Wrap:
  - Stimulus: write 14 bytes, retire 12, write 0xDDCCBBAA len4.
  - Response: used=6 and fetch bytes in order 0x0D,0x0E,0xAA,0xBB,0xCC,0xDD (pointer wrap at 16).
- Full / overflow:
  - Stimulus: fill to used=13; space_ok=0; write len4.
  - Response: beat dropped, used stays 13, overflow=1. Same cycle with dec_accept=8: still dropped; used then becomes 5.
- Limit marker:
  - Stimulus: write len3, then signal_limit_do; retire 3.
  - Response: fetch_limit=0 while used>0, fetch_limit=1 the cycle used reaches 0; further writes ignored.
- Simultaneous limit+pf, then pr_reset:
  - Stimulus: limit and pf in the same cycle on an empty queue, then pr_reset.
  - Response: fetch_page_fault=1 and fetch_limit=0; after pr_reset both are 0, used=0 and space_ok=1.
- Clamp and reset mid-operation:
  - Stimulus: dec_accept=8 with fetch_valid=2, then rst_n low for one cycle with used=7.
  - Response: used goes 0 without underflow; after reset all outputs are at reset values, including overflow=0.

Source files
------------

// File: rtl/prefetch_queue_pkg.sv
// Shared definitions for the prefetch queue: boolean constants, default
// depth and the encoding of the terminal marker held behind the data.
package prefetch_queue_pkg;

  localparam bit TRUE  = 1'b1;
  localparam bit FALSE = 1'b0;

  localparam int PREFETCH_QUEUE_DEPTH = 16;

  // Terminal marker that logically follows the last queued byte.
  typedef enum logic [1:0] {
    MK_NONE  = 2'd0,
    MK_LIMIT = 2'd1,
    MK_PF    = 2'd2
  } marker_e;

endpackage

// File: rtl/prefetch_queue_ring.sv
// Byte ring storage for the prefetch queue.
//   clk      : clock
//   wr_en    : write the first wr_len bytes of wr_data starting at wr_ptr
//   wr_ptr   : ring index of byte [7:0] of wr_data
//   wr_data  : beat bytes, [7:0] lowest address
//   wr_len   : bytes to write, 0..4
//   rd_ptr   : ring index of the oldest byte
//   rd_win   : 8 bytes starting at rd_ptr, wrapping modulo DEPTH (unmasked)
module prefetch_queue_ring #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [PTR_W-1:0]      wr_ptr,
  input  logic [31:0]           wr_data,
  input  logic [2:0]            wr_len,
  input  logic [PTR_W-1:0]      rd_ptr,
  output logic [7:0][7:0]       rd_win
);

  logic [7:0] mem [DEPTH];

  // Contents need no reset: bytes outside the valid window are masked above.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en && (3'(i) < wr_len))
        mem[wr_ptr + PTR_W'(i)] <= wr_data[8*i +: 8];
    end
  end

  for (genvar i = 0; i < 8; i++) begin : g_rd
    logic [PTR_W-1:0] idx;
    assign idx       = rd_ptr + PTR_W'(i);
    assign rd_win[i] = mem[idx];
  end

endmodule

// File: rtl/prefetch_queue.sv
// Byte-granular instruction prefetch queue between the prefetch/icache return
// path and the decoder.
//   clk, rst_n                     : clock, synchronous active-low reset
//   pr_reset                       : flush on control transfer
//   prefetchfifo_write_do/data/length : 1..4 byte fetch beat
//   prefetchfifo_signal_limit_do   : CS-limit marker
//   prefetchfifo_signal_pf_do      : page-fault marker
//   prefetchfifo_space_ok          : >=4 bytes free and no marker pending
//   prefetchfifo_used              : bytes held
//   fetch / fetch_valid            : up to 8 oldest bytes, [7:0] oldest
//   fetch_limit / fetch_page_fault : drained with marker pending
//   dec_accept                     : bytes retired by the decoder
//   prefetchfifo_overflow          : sticky, a beat was dropped
module prefetch_queue
  import prefetch_queue_pkg::*;
#(
  parameter  int DEPTH = PREFETCH_QUEUE_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pr_reset,
  input  logic             prefetchfifo_write_do,
  input  logic [31:0]      prefetchfifo_write_data,
  input  logic [2:0]       prefetchfifo_write_length,
  input  logic             prefetchfifo_signal_limit_do,
  input  logic             prefetchfifo_signal_pf_do,
  output logic             prefetchfifo_space_ok,
  output logic [PTR_W:0]   prefetchfifo_used,
  output logic [63:0]      fetch,
  output logic [3:0]       fetch_valid,
  output logic             fetch_limit,
  output logic             fetch_page_fault,
  input  logic [3:0]       dec_accept,
  output logic             prefetchfifo_overflow
);

  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0]   used, free;
  marker_e          marker;
  logic             overflow;
  logic [2:0]       wlen, wlen_acc;
  logic             wr_req, wr_acc;
  logic [3:0]       eff_accept;
  logic [7:0][7:0]  win;

  assign free        = (PTR_W+1)'(DEPTH) - used;
  assign fetch_valid = (used >= (PTR_W+1)'(8)) ? 4'd8 : 4'(used);

  // Beats never exceed 4 bytes; a length of 0 is no write.
  assign wlen     = (prefetchfifo_write_length > 3'd4) ? 3'd4 : prefetchfifo_write_length;
  assign wr_req   = prefetchfifo_write_do && (wlen != 3'd0);
  // Space judged on pre-retire occupancy: a full queue cannot refill while draining.
  assign wr_acc   = wr_req && (marker == MK_NONE) && (free >= (PTR_W+1)'(wlen));
  assign wlen_acc = wr_acc ? wlen : 3'd0;

  assign eff_accept = (dec_accept > fetch_valid) ? fetch_valid : dec_accept;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      used     <= '0;
      marker   <= MK_NONE;
      overflow <= 1'b0;
    end else if (pr_reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      used   <= '0;
      marker <= MK_NONE;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(wlen_acc);
      rd_ptr <= rd_ptr + PTR_W'(eff_accept);
      used   <= used + (PTR_W+1)'(wlen_acc) - (PTR_W+1)'(eff_accept);
      if (wr_req && !wr_acc)
        overflow <= 1'b1;
      // First marker wins; page fault beats limit when both arrive together.
      if (marker == MK_NONE) begin
        if (prefetchfifo_signal_pf_do)         marker <= MK_PF;
        else if (prefetchfifo_signal_limit_do) marker <= MK_LIMIT;
      end
    end
  end

  prefetch_queue_ring #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ring (
    .clk     (clk),
    .wr_en   (wr_acc && !pr_reset),
    .wr_ptr  (wr_ptr),
    .wr_data (prefetchfifo_write_data),
    .wr_len  (wlen),
    .rd_ptr  (rd_ptr),
    .rd_win  (win)
  );

  for (genvar i = 0; i < 8; i++) begin : g_fetch
    assign fetch[8*i +: 8] = (4'(i) < fetch_valid) ? win[i] : 8'h00;
  end

  assign prefetchfifo_space_ok = (free >= (PTR_W+1)'(4)) && (marker == MK_NONE);
  assign prefetchfifo_used     = used;
  assign fetch_limit           = (marker == MK_LIMIT) && (used == '0);
  assign fetch_page_fault      = (marker == MK_PF) && (used == '0);
  assign prefetchfifo_overflow = overflow;

endmodule

// File: tb/tb_prefetch_queue.sv
module tb_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pr_reset;
  logic        prefetchfifo_write_do;
  logic [31:0] prefetchfifo_write_data;
  logic [2:0]  prefetchfifo_write_length;
  logic        prefetchfifo_signal_limit_do;
  logic        prefetchfifo_signal_pf_do;
  logic        prefetchfifo_space_ok;
  logic [4:0]  prefetchfifo_used;
  logic [63:0] fetch;
  logic [3:0]  fetch_valid;
  logic        fetch_limit;
  logic        fetch_page_fault;
  logic [3:0]  dec_accept;
  logic        prefetchfifo_overflow;

  always #5 clk = ~clk;

  prefetch_queue dut (
    .clk                          (clk),
    .rst_n                        (rst_n),
    .pr_reset                     (pr_reset),
    .prefetchfifo_write_do        (prefetchfifo_write_do),
    .prefetchfifo_write_data      (prefetchfifo_write_data),
    .prefetchfifo_write_length    (prefetchfifo_write_length),
    .prefetchfifo_signal_limit_do (prefetchfifo_signal_limit_do),
    .prefetchfifo_signal_pf_do    (prefetchfifo_signal_pf_do),
    .prefetchfifo_space_ok        (prefetchfifo_space_ok),
    .prefetchfifo_used            (prefetchfifo_used),
    .fetch                        (fetch),
    .fetch_valid                  (fetch_valid),
    .fetch_limit                  (fetch_limit),
    .fetch_page_fault             (fetch_page_fault),
    .dec_accept                   (dec_accept),
    .prefetchfifo_overflow        (prefetchfifo_overflow)
  );

  // Scoreboard: bytes queued in write order, popped as the decoder retires them.
  logic [7:0] mq[$];
  int         mk;    // 0 none, 1 limit, 2 page fault
  bit         movf;
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [63:0] ef;
    int          sz;
    int          fv;
    sz = mq.size();
    fv = (sz > 8) ? 8 : sz;
    ef = '0;
    for (int i = 0; i < fv; i++) ef[8*i +: 8] = mq[i];
    chk("used",     64'(prefetchfifo_used), 64'(sz));
    chk("fvalid",   64'(fetch_valid), 64'(fv));
    chk("fetch",    fetch, ef);
    chk("space_ok", 64'(prefetchfifo_space_ok), 64'((16 - sz >= 4) && mk == 0));
    chk("limit",    64'(fetch_limit), 64'(mk == 1 && sz == 0));
    chk("pf",       64'(fetch_page_fault), 64'(mk == 2 && sz == 0));
    chk("overflow", 64'(prefetchfifo_overflow), 64'(movf));
  endtask

  task automatic idle();
    pr_reset = 1'b0;
    prefetchfifo_write_do = 1'b0;
    prefetchfifo_write_data = '0;
    prefetchfifo_write_length = '0;
    prefetchfifo_signal_limit_do = 1'b0;
    prefetchfifo_signal_pf_do = 1'b0;
    dec_accept = '0;
  endtask

  // Advance the model with the driven inputs, clock once, then compare.
  task automatic step();
    int sz;
    int fv;
    int ea;
    int wl;
    sz = mq.size();
    fv = (sz > 8) ? 8 : sz;
    if (!rst_n) begin
      mq.delete(); mk = 0; movf = 1'b0;
    end else if (pr_reset) begin
      mq.delete(); mk = 0;
    end else begin
      ea = (int'(dec_accept) > fv) ? fv : int'(dec_accept);
      wl = prefetchfifo_write_do ? int'(prefetchfifo_write_length) : 0;
      for (int i = 0; i < ea; i++) void'(mq.pop_front());
      if (wl != 0) begin
        if (mk == 0 && 16 - sz >= wl)
          for (int i = 0; i < wl; i++) mq.push_back(prefetchfifo_write_data[8*i +: 8]);
        else
          movf = 1'b1;
      end
      if (mk == 0) begin
        if (prefetchfifo_signal_pf_do)         mk = 2;
        else if (prefetchfifo_signal_limit_do) mk = 1;
      end
    end
    @(posedge clk);
    #1;
    idle();
    rst_n = 1'b1;
    check_all();
  endtask

  task automatic wr(input logic [31:0] d, input logic [2:0] len);
    prefetchfifo_write_do = 1'b1;
    prefetchfifo_write_data = d;
    prefetchfifo_write_length = len;
  endtask

  initial begin
    idle();
    mk = 0;
    movf = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    step();
    chk("rst_used", 64'(prefetchfifo_used), 64'd0);
    chk("rst_space", 64'(prefetchfifo_space_ok), 64'd1);

    // Basic fill and drain
    wr(32'h44332211, 3'd4); step();
    chk("fill_used4", 64'(prefetchfifo_used), 64'd4);
    wr(32'h88776655, 3'd4); step();
    chk("fill_used8", 64'(prefetchfifo_used), 64'd8);
    chk("fill_fetch", fetch, 64'h8877665544332211);
    dec_accept = 4'd3; step();
    chk("drain_fv5", 64'(fetch_valid), 64'd5);
    chk("drain_fetch", fetch, 64'h0000008877665544);

    // Wrap: restart pointers at 0, write 14 bytes, retire 12, write 4
    pr_reset = 1'b1; step();
    wr(32'h04030201, 3'd4); step();
    wr(32'h08070605, 3'd4); step();
    wr(32'h0C0B0A09, 3'd4); step();
    wr(32'h00000E0D, 3'd2); step();
    dec_accept = 4'd8; step();
    dec_accept = 4'd4; step();
    wr(32'hDDCCBBAA, 3'd4); step();
    chk("wrap_used", 64'(prefetchfifo_used), 64'd6);
    chk("wrap_fetch", fetch, 64'h0000DDCCBBAA0E0D);

    // Full / overflow
    wr(32'h14131211, 3'd4); step();
    wr(32'h00232221, 3'd3); step();
    chk("full_space", 64'(prefetchfifo_space_ok), 64'd0);
    wr(32'h34333231, 3'd4); step();
    chk("ovf_used", 64'(prefetchfifo_used), 64'd13);
    chk("ovf_flag", 64'(prefetchfifo_overflow), 64'd1);
    wr(32'h44434241, 3'd4); dec_accept = 4'd8; step();
    chk("ovf_drain", 64'(prefetchfifo_used), 64'd5);
    // Exact fit to capacity
    wr(32'h54535251, 3'd4); step();
    wr(32'h64636261, 3'd4); step();
    wr(32'h00737271, 3'd3); step();
    chk("cap_used", 64'(prefetchfifo_used), 64'd16);
    dec_accept = 4'd8; step();
    dec_accept = 4'd8; step();

    // Limit marker
    wr(32'h00CCBBAA, 3'd3); step();
    prefetchfifo_signal_limit_do = 1'b1; step();
    chk("lim_held", 64'(fetch_limit), 64'd0);
    wr(32'h11111111, 3'd4); step();
    chk("lim_block", 64'(prefetchfifo_used), 64'd3);
    dec_accept = 4'd3; step();
    chk("lim_out", 64'(fetch_limit), 64'd1);
    pr_reset = 1'b1; step();

    // Limit and page fault together, then flush
    prefetchfifo_signal_limit_do = 1'b1; prefetchfifo_signal_pf_do = 1'b1; step();
    chk("both_pf", 64'(fetch_page_fault), 64'd1);
    chk("both_lim", 64'(fetch_limit), 64'd0);
    pr_reset = 1'b1; wr(32'h12345678, 3'd4);
    #1 check_all();   // outputs still show pre-flush state
    step();
    chk("flush_pf", 64'(fetch_page_fault), 64'd0);
    chk("flush_space", 64'(prefetchfifo_space_ok), 64'd1);

    // Clamp, then reset mid-operation
    wr(32'h0000BEEF, 3'd2); step();
    dec_accept = 4'd8; step();
    chk("clamp_used", 64'(prefetchfifo_used), 64'd0);
    wr(32'hA3A2A1A0, 3'd4); step();
    wr(32'h00B2B1B0, 3'd3); step();
    chk("pre_rst_used", 64'(prefetchfifo_used), 64'd7);
    rst_n = 1'b0; wr(32'hFFFFFFFF, 3'd4); step();
    chk("mid_rst_ovf", 64'(prefetchfifo_overflow), 64'd0);
    chk("mid_rst_fetch", fetch, 64'd0);

    // Random traffic against the scoreboard
    for (int n = 0; n < 200; n++) begin
      prefetchfifo_write_do = 1'($urandom_range(0, 1));
      prefetchfifo_write_data = $urandom;
      prefetchfifo_write_length = 3'($urandom_range(0, 4));
      dec_accept = 4'($urandom_range(0, 8));
      pr_reset = ($urandom_range(0, 24) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
